sp_ram_arbiter: RTL and testbench

Two-port request/grant arbiter that shares one single-port data/instruction RAM (the `sp_ram_wrap` instance) between two masters. Port 0 is the core instruction fetch and port 1 is core data / debug. The block grants at most one access per cycle and drives the RAM control signals. It tracks the one-cycle read latency so the response goes back to the port that owns it. It sits between the core/AXI-to-mem adapters and the RAM wrapper.

---
 rtl/sp_ram_arb_pkg.sv | 31 +++
 rtl/sp_ram_arbiter_rr_arb2.sv | 42 ++++
 rtl/sp_ram_arbiter.sv | 122 ++++++++++++
 tb/tb_sp_ram_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// rtl/sp_ram_arb_pkg.sv - shared types and constants for the single-port RAM arbiter
package sp_ram_arb_pkg;

  // Port identities; the numeric value is also the grant/owner bit index.
  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_id_t;

  // Default request widths (32 KiB RAM, 32-bit data).
  localparam int unsigned REQ_ADDR_W = 15;
  localparam int unsigned REQ_DATA_W = 32;
  localparam int unsigned REQ_BE_W   = REQ_DATA_W / 8;

  // One RAM access as presented by a master.
  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  we;
    logic [REQ_BE_W-1:0]   be;
    logic [REQ_DATA_W-1:0] wdata;
  } ram_req_t;

  // Reset value of the last-granted tracker: port 0 wins the first conflict.
  localparam port_id_t LAST_RESET = PORT_DATA;

  // Map a one-hot two-port grant to the winning port id (port 0 when idle).
  function automatic port_id_t gnt_to_port(input logic [1:0] gnt);
    return gnt[1] ? PORT_DATA : PORT_INSTR;
  endfunction

endpackage

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// rtl/sp_ram_arbiter_rr_arb2.sv - two-input round-robin grant logic with last-granted register
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_id_t last_q;
  port_id_t last_d;

  // Grant: a lone requester wins; on a conflict the port not granted last time wins.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == PORT_DATA) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Next-state for the last-granted tracker; it only moves when something is granted.
  always_comb begin
    last_d = last_q;
    if (gnt_o != 2'b00) begin
      last_d = gnt_to_port(gnt_o);
    end
  end

  // Last-granted register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      last_q <= LAST_RESET;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - two-master single-port RAM arbiter; SP_RAM_ARB_FIXED_PRIO_EN selects fixed priority (port 1 wins)
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,

  input  logic                    p0_req_i,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_gnt_o,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,

  input  logic                    p1_req_i,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_gnt_o,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  // Request bundle at this instance's widths.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  logic [1:0] req_eff;
  logic [1:0] gnt;
  req_t       p0_req;
  req_t       p1_req;
  req_t       ram_req;

  logic       resp_valid_q;
  logic       resp_valid_d;
  port_id_t   resp_owner_q;
  port_id_t   resp_owner_d;

  // Requests are masked during reset so nothing is granted and the RAM stays idle.
  assign req_eff = {p1_req_i, p0_req_i} & {2{~rst_i}};

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
  // Fixed priority: data/debug port always wins, no history kept.
  assign gnt[1] = req_eff[1];
  assign gnt[0] = req_eff[0] & ~req_eff[1];
`else
  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_i (rst_i),
    .req_i (req_eff),
    .gnt_o (gnt)
  );
`endif

  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];

  assign p0_req = '{addr: p0_addr_i, we: p0_we_i, be: p0_be_i, wdata: p0_wdata_i};
  assign p1_req = '{addr: p1_addr_i, we: p1_we_i, be: p1_be_i, wdata: p1_wdata_i};

  // Request mux: granted port drives the RAM, all-zero when idle.
  always_comb begin
    ram_req = '0;
    if (gnt[1]) begin
      ram_req = p1_req;
    end else if (gnt[0]) begin
      ram_req = p0_req;
    end
  end

  assign ram_en_o    = gnt[0] | gnt[1];
  assign ram_addr_o  = ram_req.addr;
  assign ram_we_o    = ram_req.we;
  assign ram_be_o    = ram_req.be;
  assign ram_wdata_o = ram_req.wdata;

  // Response pipeline next-state: remember whether an access issued and who owns it.
  always_comb begin
    resp_valid_d = ram_en_o;
    resp_owner_d = gnt_to_port(gnt);
  end

  // Response pipeline registers; reset discards any in-flight response.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= PORT_INSTR;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Steer the RAM response to its owner; reset suppresses a response landing in the reset cycle.
  always_comb begin
    p0_rvalid_o = resp_valid_q & ~rst_i & (resp_owner_q == PORT_INSTR);
    p1_rvalid_o = resp_valid_q & ~rst_i & (resp_owner_q == PORT_DATA);
    p0_rdata_o  = p0_rvalid_o ? ram_rdata_i : '0;
    p1_rdata_o  = p1_rvalid_o ? ram_rdata_i : '0;
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - table-driven self-checking bench for sp_ram_arbiter
module tb_sp_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          p0_req_i, p1_req_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic          p0_we_i, p1_we_i;
  logic [3:0]    p0_be_i, p1_be_i;
  logic [DW-1:0] p0_wdata_i, p1_wdata_i;
  logic          p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
  logic [DW-1:0] p0_rdata_o, p1_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [3:0]    ram_be_o;
  logic [DW-1:0] ram_rdata_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter dut (
    .clk(clk), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
    .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
    .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
  );

  // Behavioural single-port RAM: one-cycle read latency, byte-enabled writes.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
      end
      ram_rdata_i <= mem[ram_addr_o[7:2]];
    end
  end

  typedef struct {
    logic        rst, r0, r1, we1;
    logic [14:0] a0, a1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic        g0, g1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        rd_dc;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  function automatic vec_t mk(input logic rst, r0, r1, we1, input logic [14:0] a0, a1,
                              input logic [31:0] wd1, input logic [3:0] be1,
                              input logic g0, g1, rv0, rv1,
                              input logic [31:0] rd0, rd1, input logic rd_dc);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.we1 = we1; v.a0 = a0; v.a1 = a1;
    v.wd1 = wd1; v.be1 = be1; v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1;
    v.rd0 = rd0; v.rd1 = rd1; v.rd_dc = rd_dc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_i      = v.rst;
    p0_req_i   = v.r0;  p0_addr_i = v.a0;  p0_we_i = 1'b0; p0_be_i = 4'hF; p0_wdata_i = '0;
    p1_req_i   = v.r1;  p1_addr_i = v.a1;  p1_we_i = v.we1; p1_be_i = v.be1; p1_wdata_i = v.wd1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    logic [14:0] ea;
    logic [31:0] ewd;
    logic [3:0]  ebe;
    logic        ewe;
    ea  = v.g1 ? v.a1  : (v.g0 ? v.a0  : 15'd0);
    ewd = v.g1 ? v.wd1 : 32'd0;
    ebe = v.g1 ? v.be1 : (v.g0 ? 4'hF : 4'h0);
    ewe = v.g1 ? v.we1 : 1'b0;
    chk({tag, " p0_gnt"},    32'(p0_gnt_o),    32'(v.g0));
    chk({tag, " p1_gnt"},    32'(p1_gnt_o),    32'(v.g1));
    chk({tag, " gnt_excl"},  32'(p0_gnt_o & p1_gnt_o), 32'd0);
    chk({tag, " p0_rvalid"}, 32'(p0_rvalid_o), 32'(v.rv0));
    chk({tag, " p1_rvalid"}, 32'(p1_rvalid_o), 32'(v.rv1));
    chk({tag, " p0_rdata"},  p0_rdata_o,       v.rd0);
    if (!v.rd_dc) chk({tag, " p1_rdata"}, p1_rdata_o, v.rd1);
    chk({tag, " ram_en"},    32'(ram_en_o),    32'(v.g0 | v.g1));
    chk({tag, " ram_addr"},  32'(ram_addr_o),  32'(ea));
    chk({tag, " ram_we"},    32'(ram_we_o),    32'(ewe));
    chk({tag, " ram_be"},    32'(ram_be_o),    32'(ebe));
    chk({tag, " ram_wdata"}, ram_wdata_o,      ewd);
  endtask

  localparam logic [31:0] W1 = 32'h1000_0001;
  localparam logic [31:0] W2 = 32'h1000_0002;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h1234_5678;
    ram_rdata_i = '0;

    //            rst r0 r1 we  a0     a1     wd1           be    g0 g1 rv0 rv1 rd0            rd1  dc
    vt[0]  = mk(1, 1, 1, 0, 15'h10, 15'h08, 0,            4'h0, 0, 0, 0, 0, 0,             0,   0);
    vt[1]  = mk(0, 1, 0, 0, 15'h10, 15'h00, 0,            4'h0, 1, 0, 0, 0, 0,             0,   0);
    vt[2]  = mk(0, 0, 0, 0, 15'h00, 15'h00, 0,            4'h0, 0, 0, 1, 0, 32'hDEADBEEF, 0,   0);
    vt[3]  = mk(1, 0, 0, 0, 15'h00, 15'h00, 0,            4'h0, 0, 0, 0, 0, 0,             0,   0);
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    vt[4]  = mk(0, 1, 1, 0, 15'h04, 15'h08, 0,            4'h0, 0, 1, 0, 0, 0,             0,   0);
    for (int k = 5; k < 10; k++)
      vt[k] = mk(0, 1, 1, 0, 15'h04, 15'h08, 0,           4'h0, 0, 1, 0, 1, 0,             W2,  0);
`else
    vt[4]  = mk(0, 1, 1, 0, 15'h04, 15'h08, 0,            4'h0, 1, 0, 0, 0, 0,             0,   0);
    vt[5]  = mk(0, 1, 1, 0, 15'h04, 15'h08, 0,            4'h0, 0, 1, 1, 0, W1,            0,   0);
    vt[6]  = mk(0, 1, 1, 0, 15'h04, 15'h08, 0,            4'h0, 1, 0, 0, 1, 0,             W2,  0);
    vt[7]  = mk(0, 1, 1, 0, 15'h04, 15'h08, 0,            4'h0, 0, 1, 1, 0, W1,            0,   0);
    vt[8]  = mk(0, 1, 1, 0, 15'h04, 15'h08, 0,            4'h0, 1, 0, 0, 1, 0,             W2,  0);
    vt[9]  = mk(0, 1, 1, 0, 15'h04, 15'h08, 0,            4'h0, 0, 1, 1, 0, W1,            0,   0);
`endif
    vt[10] = mk(0, 1, 0, 0, 15'h04, 15'h00, 0,            4'h0, 1, 0, 0, 1, 0,             W2,  0);
    vt[11] = mk(0, 0, 1, 1, 15'h00, 15'h20, 32'hA5A5A5A5, 4'h3, 0, 1, 1, 0, W1,            0,   0);
    vt[12] = mk(0, 1, 0, 0, 15'h20, 15'h00, 0,            4'h0, 1, 0, 0, 1, 0,             0,   1);
    vt[13] = mk(0, 0, 0, 0, 15'h00, 15'h00, 0,            4'h0, 0, 0, 1, 0, 32'h1234A5A5, 0,   0);

    drive(vt[0]);
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      check_vec($sformatf("row%0d", i), vt[i]);
    end

    // Reset while a port-0 read is in flight: the response must never appear.
    @(negedge clk);
    drive(mk(0, 1, 0, 0, 15'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1; chk("inflight grant", 32'(p0_gnt_o), 32'd1);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1; chk("inflight rvalid in reset", 32'(p0_rvalid_o), 32'd0);
    chk("inflight rdata in reset", p0_rdata_o, 32'd0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1; chk("inflight rvalid after reset", 32'(p0_rvalid_o), 32'd0);
    chk("p1 rvalid after reset", 32'(p1_rvalid_o), 32'd0);

    // First conflict after reset release.
    @(negedge clk);
    drive(mk(0, 1, 1, 0, 15'h04, 15'h08, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    chk("post-reset conflict p1_gnt", 32'(p1_gnt_o), 32'd1);
    chk("post-reset conflict p0_gnt", 32'(p0_gnt_o), 32'd0);
`else
    chk("post-reset conflict p0_gnt", 32'(p0_gnt_o), 32'd1);
    chk("post-reset conflict p1_gnt", 32'(p1_gnt_o), 32'd0);
`endif
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    chk("post-reset resp p1_rvalid", 32'(p1_rvalid_o), 32'd1);
    chk("post-reset resp p1_rdata", p1_rdata_o, W2);
`else
    chk("post-reset resp p0_rvalid", 32'(p0_rvalid_o), 32'd1);
    chk("post-reset resp p0_rdata", p0_rdata_o, W1);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
